// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider controller:
// register-bank indices, input-mux codes, ALU opcodes, state encoding
// and the control word handed from the micro-op decoder to the top.
package div_pkg;

    localparam logic [3:0] REG_Q     = 4'd0;
    localparam logic [3:0] REG_ALU_A = 4'd1;
    localparam logic [3:0] REG_ALU_B = 4'd2;
    localparam logic [3:0] REG_DIV   = 4'd3;
    localparam logic [3:0] REG_R     = 4'd14;

    localparam logic [2:0] MUX_IN_A  = 3'd0;
    localparam logic [2:0] MUX_IN_B  = 3'd1;
    localparam logic [2:0] MUX_CONST = 3'd2;
    localparam logic [2:0] MUX_ALU   = 3'd3;
    localparam logic [2:0] MUX_REG   = 3'd4;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    // state   | meaning
    // IDLE    | waiting for start, all controls 0
    // LOAD_A  | R14 <- InA (dividend, becomes running remainder)
    // LOAD_B  | R3  <- InB (divisor)
    // CLR_Q   | R0  <- 0 (quotient)
    // LD1/LD2 | stage R14, R3 into ALU operands R1, R2
    // SUB     | R14 <- R1 - R2 unless borrow, borrow ends the loop
    // INC1/2  | stage R0 and constant 1 into R1, R2
    // ADD     | R0 <- R1 + R2
    // DONE    | one-cycle result-valid pulse
    // CZ1..3  | divisor-zero test (R3 - 0), optional
    // ZERR    | R0 <- 0xFF, err raised, optional
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_CLR_Q, S_LD1, S_LD2, S_SUB,
        S_INC1, S_INC2, S_ADD, S_DONE, S_CZ1, S_CZ2, S_CZ3, S_ZERR
    } state_t;

    typedef struct packed {
        logic [2:0] in_mux;
        logic       we;
        logic [3:0] reg_add;
        logic [3:0] out_mux;
        logic [7:0] cu_const;
        logic [1:0] alu_op;
        logic       busy;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/div_cu_uop_decode.sv
// Micro-op decoder: maps the controller state (and the ALU borrow in SUB)
// to the register-bank / ALU control word. Purely combinational.
// CZ/ZERR micro-ops exist only when DIV_ZERO_CHECK_EN is defined.
module div_cu_uop_decode
    import div_pkg::*;
(
    input  state_t     state,
    input  logic       alu_borrow,
    output ctrl_t      ctrl
);

    // Moore decode of the state; SUB write-enable depends on the borrow
    always_comb begin
        ctrl      = '0;
        ctrl.busy = (state != S_IDLE) && (state != S_DONE);
        case (state)
            S_LOAD_A: begin ctrl.in_mux = MUX_IN_A; ctrl.reg_add = REG_R; ctrl.we = 1'b1; end
            S_LOAD_B: begin ctrl.in_mux = MUX_IN_B; ctrl.reg_add = REG_DIV; ctrl.we = 1'b1; end
            S_CLR_Q: begin
                ctrl.in_mux = MUX_CONST; ctrl.cu_const = 8'd0; ctrl.reg_add = REG_Q; ctrl.we = 1'b1;
            end
            S_LD1: begin
                ctrl.in_mux = MUX_REG; ctrl.out_mux = REG_R; ctrl.reg_add = REG_ALU_A; ctrl.we = 1'b1;
            end
            S_LD2: begin
                ctrl.in_mux = MUX_REG; ctrl.out_mux = REG_DIV; ctrl.reg_add = REG_ALU_B; ctrl.we = 1'b1;
            end
            S_SUB: begin
                ctrl.alu_op = ALU_SUB; ctrl.in_mux = MUX_ALU; ctrl.reg_add = REG_R; ctrl.we = !alu_borrow;
            end
            S_INC1: begin
                ctrl.in_mux = MUX_REG; ctrl.out_mux = REG_Q; ctrl.reg_add = REG_ALU_A; ctrl.we = 1'b1;
            end
            S_INC2: begin
                ctrl.in_mux = MUX_CONST; ctrl.cu_const = 8'd1; ctrl.reg_add = REG_ALU_B; ctrl.we = 1'b1;
            end
            S_ADD: begin
                ctrl.alu_op = ALU_ADD; ctrl.in_mux = MUX_ALU; ctrl.reg_add = REG_Q; ctrl.we = 1'b1;
            end
            S_DONE: ctrl.done = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            S_CZ1: begin
                ctrl.in_mux = MUX_REG; ctrl.out_mux = REG_DIV; ctrl.reg_add = REG_ALU_A; ctrl.we = 1'b1;
            end
            S_CZ2: begin
                ctrl.in_mux = MUX_CONST; ctrl.cu_const = 8'd0; ctrl.reg_add = REG_ALU_B; ctrl.we = 1'b1;
            end
            S_CZ3: ctrl.alu_op = ALU_SUB;
            S_ZERR: begin
                ctrl.in_mux = MUX_CONST; ctrl.cu_const = 8'hFF; ctrl.reg_add = REG_Q; ctrl.we = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/div_control_unit.sv
// Control FSM for the 8-bit repeated-subtraction divider. Holds the state
// register and next-state logic; the control word comes from
// div_cu_uop_decode. Quotient ends in R0, remainder in R14.
// Optional macro DIV_ZERO_CHECK_EN adds a divisor-zero test and err flag;
// without it err is tied low and B=0 never terminates (reset recovers).
module div_control_unit
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       alu_borrow,
    input  logic       alu_zero,
    output logic [2:0] InMuxAdd,
    output logic       WE,
    output logic [3:0] RegAdd,
    output logic [3:0] OutMuxAdd,
    output logic [7:0] CUconst,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t state, state_nxt;
    ctrl_t  ctrl;

    div_cu_uop_decode u_decode (
        .state      (state),
        .alu_borrow (alu_borrow),
        .ctrl       (ctrl)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state sequencing of the micro-program
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD_A;
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_CLR_Q;
`ifdef DIV_ZERO_CHECK_EN
            S_CLR_Q:  state_nxt = S_CZ1;
            S_CZ1:    state_nxt = S_CZ2;
            S_CZ2:    state_nxt = S_CZ3;
            S_CZ3:    state_nxt = alu_zero ? S_ZERR : S_LD1;
            S_ZERR:   state_nxt = S_DONE;
`else
            S_CLR_Q:  state_nxt = S_LD1;
`endif
            S_LD1:    state_nxt = S_LD2;
            S_LD2:    state_nxt = S_SUB;
            S_SUB:    state_nxt = alu_borrow ? S_DONE : S_INC1;
            S_INC1:   state_nxt = S_INC2;
            S_INC2:   state_nxt = S_ADD;
            S_ADD:    state_nxt = S_LD1;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

`ifdef DIV_ZERO_CHECK_EN
    logic err_q;

    // Carry err from ZERR into the following DONE cycle; any other state clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= (state == S_ZERR);
    end

    assign err = err_q | (state == S_ZERR);
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
    assign err = 1'b0;
`endif

    assign InMuxAdd  = ctrl.in_mux;
    assign WE        = ctrl.we;
    assign RegAdd    = ctrl.reg_add;
    assign OutMuxAdd = ctrl.out_mux;
    assign CUconst   = ctrl.cu_const;
    assign alu_op    = ctrl.alu_op;
    assign busy      = ctrl.busy;
    assign done      = ctrl.done;

endmodule

// File: tb/tb_div_control_unit.sv
// Bench for div_control_unit: a behavioural 16x8 register bank and ALU
// close the loop around the controller; results are checked against
// plain integer division.
module tb_div_control_unit;

`ifdef DIV_ZERO_CHECK_EN
    localparam int XTRA = 3;
`else
    localparam int XTRA = 0;
`endif
    localparam int MAXC = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       alu_borrow, alu_zero;
    logic [2:0] InMuxAdd;
    logic       WE;
    logic [3:0] RegAdd, OutMuxAdd;
    logic [7:0] CUconst;
    logic [1:0] alu_op;
    logic       busy, done, err;

    logic [7:0] in_a = 8'd0, in_b = 8'd0;
    logic [7:0] bank [16];
    logic [7:0] alu_out;
    int         r14_writes = 0;

    int checks = 0;
    int errors = 0;

    div_control_unit dut (
        .clk(clk), .rst(rst), .start(start),
        .alu_borrow(alu_borrow), .alu_zero(alu_zero),
        .InMuxAdd(InMuxAdd), .WE(WE), .RegAdd(RegAdd), .OutMuxAdd(OutMuxAdd),
        .CUconst(CUconst), .alu_op(alu_op),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // ALU model fed from R1/R2
    always_comb begin
        case (alu_op)
            2'd1:    alu_out = bank[1] + bank[2];
            2'd2:    alu_out = bank[1] - bank[2];
            default: alu_out = bank[1];
        endcase
        alu_borrow = bank[1] < bank[2];
        alu_zero   = (alu_out == 8'd0);
    end

    // Register bank model and R14 write counter
    always @(posedge clk) begin
        if (WE) begin
            case (InMuxAdd)
                3'd0:    bank[RegAdd] <= in_a;
                3'd1:    bank[RegAdd] <= in_b;
                3'd2:    bank[RegAdd] <= CUconst;
                3'd3:    bank[RegAdd] <= alu_out;
                default: bank[RegAdd] <= bank[OutMuxAdd];
            endcase
            if (RegAdd == 4'd14) r14_writes <= r14_writes + 1;
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         q;
        int         r;
        int         nbusy;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one division from an IDLE negedge; returns at the DONE negedge
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int nbusy, output bit seen_done, output bit seen_err);
        in_a = a; in_b = b;
        nbusy = 0; seen_done = 0; seen_err = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < MAXC && !seen_done; i++) begin
            if (done) begin
                seen_done = 1; seen_err = err;
            end else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic recover();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input int q, input int r, input int nb);
        int  nbusy, w0;
        bit  sd, se;
        w0 = r14_writes;
        run_op(a, b, nbusy, sd, se);
        chk({tag, "_done"}, int'(sd), 1);
        if (!sd) begin
            recover();
        end else begin
            chk({tag, "_busy"}, nbusy, nb);
            chk({tag, "_q"}, int'(bank[0]), q);
            chk({tag, "_r"}, int'(bank[14]), r);
            chk({tag, "_err"}, int'(se), 0);
            chk({tag, "_r14wr"}, r14_writes - w0, 1 + q);
            @(negedge clk);
            chk({tag, "_pulse"}, int'({done, busy}), 0);
        end
    endtask

    initial begin
        int  nbusy, q, r;
        bit  sd, se;
        logic [7:0] a, b;

        vecs[0] = '{8'd100, 8'd7, 14, 2, 90};
        vecs[1] = '{8'd5,   8'd9, 0,  5, 6};
        vecs[2] = '{8'd255, 8'd1, 255, 0, 1536};
        vecs[3] = '{8'd0,   8'd5, 0,  0, 6};
        vecs[4] = '{8'd7,   8'd7, 1,  0, 12};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({InMuxAdd, WE, RegAdd, OutMuxAdd, CUconst, alu_op, busy, done, err}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", int'({InMuxAdd, WE, RegAdd, OutMuxAdd, CUconst, alu_op, busy, done, err}), 0);

        // Directed table
        for (int i = 0; i < 5; i++)
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                     vecs[i].nbusy + XTRA);

        // Randomized against integer division
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            check_op($sformatf("rnd%0d", i), a, b, q, r, 6 + 6 * q + XTRA);
        end

        // start held high: one op per acceptance, next accepted in the IDLE after DONE
        in_a = 8'd20; in_b = 8'd3;
        start = 1'b1;
        sd = 0;
        for (int i = 0; i < MAXC && !sd; i++) begin
            @(negedge clk);
            if (done) sd = 1;
        end
        chk("hold_first_done", int'(sd), 1);
        chk("hold_first_q", int'(bank[0]), 6);
        in_a = 8'd61; in_b = 8'd9;
        @(negedge clk);
        chk("hold_idle_gap", int'({busy, done}), 0);
        @(negedge clk);
        chk("hold_second_accept", int'(busy), 1);
        start = 1'b0;
        nbusy = 0; sd = 0;
        for (int i = 0; i < MAXC && !sd; i++) begin
            if (done) sd = 1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
        chk("hold_second_done", int'(sd), 1);
        chk("hold_second_busy", nbusy, 42 + XTRA);
        chk("hold_second_q", int'(bank[0]), 6);
        chk("hold_second_r", int'(bank[14]), 7);
        @(negedge clk);

        // Reset in the middle of an operation
        in_a = 8'd100; in_b = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1 chk("async_rst_outputs", int'({InMuxAdd, WE, RegAdd, OutMuxAdd, CUconst, alu_op, busy, done, err}), 0);
        sd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) sd = 1;
        end
        chk("rst_no_done", int'(sd), 0);
        rst = 1'b0;
        @(negedge clk);
        check_op("after_rst", 8'd100, 8'd7, 14, 2, 90 + XTRA);

`ifdef DIV_ZERO_CHECK_EN
        // Divisor zero: ZERR path, busy = LOAD_A, LOAD_B, CLR_Q, CZ1..3, ZERR
        run_op(8'd42, 8'd0, nbusy, sd, se);
        chk("zero_done", int'(sd), 1);
        chk("zero_busy", nbusy, 7);
        chk("zero_err", int'(se), 1);
        chk("zero_q", int'(bank[0]), 255);
        chk("zero_r", int'(bank[14]), 42);
        @(negedge clk);
        chk("zero_err_clear", int'(err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
